// File: rtl/branch_sequencer_pkg.sv
// branch_sequencer_pkg: shared state encodings and opcode constants for the hiddenCPU sequencer
package branch_sequencer_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, COMMIT = 2'd2} state_t;
  localparam logic [1:0] OP_MOVBR = 2'b00;
  localparam logic [1:0] OP_ALU0 = 2'b01;
  localparam logic [1:0] OP_ALU1 = 2'b10;
  localparam logic [1:0] OP_ALU2 = 2'b11;
endpackage

// File: rtl/branch_sequencer_pc_next.sv
// branch_sequencer_pc_next: next-PC select, pc+r3Val on a taken branch else pc+1 (buc > bcf > bbf)
module branch_sequencer_pc_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] r3Val,
  input  logic             isBranch,
  input  logic             carryFlag,
  input  logic             borrowFlag,
  input  logic             buc,
  input  logic             bcf,
  input  logic             bbf,
  output logic [WIDTH-1:0] pcNext
);
  logic take;
  always_comb begin
    take = isBranch && (buc ? 1'b1 : bcf ? carryFlag : bbf ? borrowFlag : 1'b0);
    pcNext = pc + (take ? r3Val : WIDTH'(1));
  end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: FETCH/EXEC/COMMIT instruction sequencer owning pc, flags and output select
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [7:0]       instrIn,
  input  logic             instrValid,
  input  logic [WIDTH-1:0] r3Val,
  input  logic             bcf,
  input  logic             bbf,
  input  logic             buc,
  input  logic             toggleOut,
  input  logic             aluCarry,
  input  logic             aluBorrow,
  output logic [WIDTH-1:0] pc,
  output logic             fetchReq,
  output logic [7:0]       instr,
  output logic             movEnable,
  output logic             aluEnable,
  output logic             regWrite,
  output logic             outSel,
  output logic             carryFlag,
  output logic             borrowFlag
);
  state_t state, nextState;
  logic isAlu, isBranch;
  logic [WIDTH-1:0] pcNext;
  assign isAlu = instr[7:6] != OP_MOVBR;
  assign isBranch = !isAlu && instr[3:2] == instr[1:0];
  branch_sequencer_pc_next #(.WIDTH(WIDTH)) pcSel (
    .pc(pc), .r3Val(r3Val), .isBranch(isBranch), .carryFlag(carryFlag),
    .borrowFlag(borrowFlag), .buc(buc), .bcf(bcf), .bbf(bbf), .pcNext(pcNext)
  );
  always_comb begin
    nextState = state == FETCH ? (run && instrValid ? EXEC : FETCH) : state == EXEC ? COMMIT : FETCH;
    fetchReq = state == FETCH;
    movEnable = state == EXEC && !isAlu;
    aluEnable = state == EXEC && isAlu;
    // gated by rst so an aborted COMMIT never strobes the register file
    regWrite = state == COMMIT && !rst && !isBranch;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= '0;
      instr <= '0;
      outSel <= 1'b0;
      carryFlag <= 1'b0;
      borrowFlag <= 1'b0;
    end else begin
      state <= nextState;
      if (state == FETCH && run && instrValid) instr <= instrIn;
      if (state == COMMIT) begin
        pc <= pcNext;
        if (isAlu) {carryFlag, borrowFlag} <= {aluCarry, aluBorrow};
        if (isBranch && toggleOut && !buc && !bcf && !bbf) outSel <= ~outSel;
      end
    end
  end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Instruction sequencer for the hiddenCPU core. It owns the 8-bit program counter, the carry/borrow flag registers and the output-pin select. It fetches one instruction byte per cycle window and steps each instruction through a fixed FETCH/EXEC/COMMIT sequence. It enables either the mov/branch unit or the ALU, and it consumes the branch strobes (unconditional, on-carry, on-borrow, output-toggle) to compute the next PC.

## Interface
Parameters:
- WIDTH, 8, datapath, PC and branch-offset width

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- run  in  1  high: sequencer may start new fetches; low: holds in FETCH after the current instruction
- instrIn  in  8  instruction byte from program source; [7:6] opcode, [3:0] register address pair
- instrValid  in  1  instrIn valid this cycle; sampled only in FETCH
- r3Val  in  WIDTH  current r3 contents, used as branch offset
- bcf, bbf, buc, toggleOut  in  1 each  branch strobes from the mov/branch unit, decoded from the latched instruction
- aluCarry, aluBorrow  in  1 each  ALU flag results for the latched ALU instruction
- pc  out  WIDTH  program counter, also the fetch address
- fetchReq  out  1  high in FETCH: requesting instrIn at pc
- instr  out  8  latched instruction, stable from EXEC through COMMIT
- movEnable  out  1  enables the mov/branch datapath output (EXEC only)
- aluEnable  out  1  enables the ALU (EXEC only)
- regWrite  out  1  register-file write strobe (COMMIT only)
- outSel  out  1  0: output pins show r3; 1: output pins show pc
- carryFlag, borrowFlag  out  1 each  architectural flags

## Operation
- States: FETCH -> EXEC -> COMMIT -> FETCH. Reset enters FETCH.
- FETCH:
  - fetchReq=1.
  - If run && instrValid: latch instrIn into instr, go to EXEC.
  - Otherwise stay in FETCH with no state change.
- EXEC:
  - opcode 00: movEnable=1.
  - opcodes 01/10/11: aluEnable=1.
  - Always go to COMMIT.
- COMMIT, opcode 00, addrs[3:2]≠addrs[1:0] (mov): regWrite=1, pc<=pc+1.
- COMMIT, opcode 00, equal addresses (branch group):
  - buc: pc<=pc+r3Val.
  - bcf: pc<=carryFlag ? pc+r3Val : pc+1.
  - bbf: pc<=borrowFlag ? pc+r3Val : pc+1.
  - toggleOut: outSel<=~outSel, pc<=pc+1.
  - No regWrite.
- COMMIT, ALU opcode: regWrite=1, carryFlag<=aluCarry, borrowFlag<=aluBorrow, pc<=pc+1.
- Branch conditions use flag values registered before the branch. Flags change only on ALU COMMIT.
- Arithmetic is modulo 2^WIDTH, unsigned. pc=255 with +1 gives 0. pc=250 with r3=10 gives 4. Offset 0xFF is effectively -1.
- buc with r3Val=0 leaves pc unchanged. This is a legal self-loop used as halt.
- More than one strobe asserted in COMMIT is a decode error. Priority is buc > bcf > bbf > toggleOut.

## Timing
- Reset values: pc=0, state=FETCH, fetchReq=1 (asserted from the first cycle after reset), instr=0, movEnable=0, aluEnable=0, regWrite=0, outSel=0, carryFlag=0, borrowFlag=0.
- Throughput: one instruction per 3 cycles minimum. Extra FETCH cycles are added while instrValid or run is low.
- pc, flags and outSel update on the clock edge that ends COMMIT and are visible in the following FETCH.
- instrValid is ignored outside FETCH. The source must hold the byte until fetchReq and instrValid are both high.
- run falling during EXEC/COMMIT: the current instruction completes, then the sequencer holds in FETCH.
- rst during EXEC or COMMIT: the instruction is aborted. No regWrite, no pc, flag or outSel update. All registers take reset values on that edge.
- Strobe inputs and r3Val are sampled only in COMMIT.

## Structure
- Shared package (decode.v-style include):
  - state encodings FETCH/EXEC/COMMIT.
  - opcode constants OP_MOVBR=2'b00, OP_ALU0..2.
- Sub-module pc_next: combinational next-PC select/adder taking pc, r3Val, flags and strobes, producing the next pc. It is reused for verification of branch math.
- The FSM, flag registers and outSel stay in branch_sequencer.

## Test plan
- Reset then instrValid with 0x1B (mov, addrs 10/11): EXEC movEnable=1; COMMIT regWrite=1; pc 0->1; 3 cycles total.
- pc=250, r3Val=10, instr 0x00 (buc): pc becomes 4 (wrap); regWrite stays 0; flags unchanged.
- ALU instr with aluCarry=1, then 0x05 (bcf), r3Val=3 at pc=7: pc=10. Repeat with carry=0: pc=8.
- Instr 0x0F (toggleOut): outSel 0->1, pc+1. A second toggle returns outSel to 0.
- run=0 asserted during EXEC: instruction commits, then fetchReq stays high and pc stays constant despite instrValid=1.
- rst pulsed in COMMIT of an ALU op with aluCarry=1: carryFlag stays 0, pc=0, regWrite never pulses.
